// File: rtl/conv_result_sink.sv
// conv_result_sink: scales and saturates the convolution result stream.
// Each sample is tagged with its output-image coordinates and buffered in a
// show-ahead FIFO that a consumer drains over valid/ready. Per-frame sample
// count and maximum are tracked, and sticky flags are raised for dropped
// samples and for frames that end with the wrong sample count.
module conv_result_sink #(
    parameter int IN_W       = 19,
    parameter int OUT_W      = 16,
    parameter int SHIFT      = 0,
    parameter int OUT_COLS   = 510,
    parameter int OUT_ROWS   = 510,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [8:0]       out_col,
    output logic [8:0]       out_row,
    output logic             out_last,
    output logic             overflow,
    output logic             frame_err,
    output logic             frame_done,
    output logic [OUT_W-1:0] max_val,
    output logic [17:0]      pix_cnt
);

    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam logic [17:0]     FRAME_PIX = 18'(OUT_COLS * OUT_ROWS);
    localparam logic [8:0]      COL_MAX   = 9'(OUT_COLS - 1);
    localparam logic [8:0]      ROW_MAX   = 9'(OUT_ROWS - 1);
    localparam logic [IN_W-1:0] SAT_LIM   = IN_W'((64'd1 << OUT_W) - 64'd1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state_reg, state_next;

    // Stage 1 pipeline register
    logic             s1_valid_reg;
    logic [OUT_W-1:0] s1_data_reg;
    logic [8:0]       s1_col_reg, s1_row_reg;
    logic             s1_last_reg;

    // Coordinate counters
    logic [8:0] col_reg, row_reg;

    // FIFO storage and pointers (one extra bit distinguishes full from empty)
    logic [OUT_W-1:0] mem_data [FIFO_DEPTH];
    logic [8:0]       mem_col  [FIFO_DEPTH];
    logic [8:0]       mem_row  [FIFO_DEPTH];
    logic             mem_last [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_reg, rd_ptr_reg;

    // Flags and statistics
    logic             overflow_reg, frame_err_reg;
    logic [17:0]      pix_cnt_reg;
    logic [OUT_W-1:0] max_val_reg;
    logic             stats_clr_reg;
    // Statistics of next-frame samples that arrive while the old frame drains
    logic [17:0]      nf_cnt_reg;
    logic [OUT_W-1:0] nf_max_reg;

    // Scale and saturate the incoming sample
    logic [IN_W-1:0]  s_in;
    logic [OUT_W-1:0] sat_in;
    assign s_in   = in_data >> SHIFT;
    assign sat_in = (s_in > SAT_LIM) ? {OUT_W{1'b1}} : s_in[OUT_W-1:0];

    logic fifo_empty, fifo_full, pop, push, drop;
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop  = !fifo_empty && out_ready;
    assign push = s1_valid_reg && (!fifo_full || pop);
    assign drop = s1_valid_reg && fifo_full && !pop;

    logic frame_done_int, done_evt, at_last, cnt_bad;
    logic [17:0] done_cnt, nf_cnt_new;
    logic [OUT_W-1:0] nf_max_new, max_new;
    assign frame_done_int = (state_reg == DRAIN) && !s1_valid_reg && fifo_empty;
    // An in_done while draining has no open frame to close, so it is ignored
    assign done_evt   = in_done && (state_reg != DRAIN);
    assign at_last    = (col_reg == COL_MAX) && (row_reg == ROW_MAX);
    assign done_cnt   = (stats_clr_reg ? 18'd0 : pix_cnt_reg) + 18'(in_valid);
    assign cnt_bad    = done_evt && (done_cnt != FRAME_PIX);
    assign nf_cnt_new = nf_cnt_reg + 18'(in_valid);
    assign nf_max_new = (in_valid && sat_in > nf_max_reg) ? sat_in : nf_max_reg;
    assign max_new    = (sat_in > max_val_reg) ? sat_in : max_val_reg;

    // Frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Frame state transitions
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (in_done)       state_next = DRAIN;
                   else if (in_valid) state_next = RUN;
            RUN:   if (in_done)       state_next = DRAIN;
            DRAIN: if (frame_done_int)
                       state_next = (nf_cnt_reg != 18'd0 || in_valid) ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stage 1: latch saturated sample together with its coordinate tags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_col_reg   <= '0;
            s1_row_reg   <= '0;
            s1_last_reg  <= 1'b0;
        end else begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_data_reg <= sat_in;
                s1_col_reg  <= col_reg;
                s1_row_reg  <= row_reg;
                s1_last_reg <= at_last;
            end
        end
    end

    // Coordinate counters; a malformed frame end resynchronises them to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (cnt_bad) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (in_valid) begin
            if (at_last) begin
                col_reg <= '0;
                row_reg <= '0;
            end else if (col_reg == COL_MAX) begin
                col_reg <= '0;
                row_reg <= row_reg + 9'd1;
            end else begin
                col_reg <= col_reg + 9'd1;
            end
        end
    end

    // FIFO storage write (contents need no reset; emptiness is in the pointers)
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_reg[AW-1:0]] <= s1_data_reg;
            mem_col[wr_ptr_reg[AW-1:0]]  <= s1_col_reg;
            mem_row[wr_ptr_reg[AW-1:0]]  <= s1_row_reg;
            mem_last[wr_ptr_reg[AW-1:0]] <= s1_last_reg;
        end
    end

    // FIFO pointers and sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (drop) overflow_reg <= 1'b1;
        end
    end

    // Sticky malformed-frame flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          frame_err_reg <= 1'b0;
        else if (cnt_bad) frame_err_reg <= 1'b1;
    end

    // Per-frame statistics; samples seen while draining are held aside and
    // become the new frame's statistics when the old frame completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt_reg   <= '0;
            max_val_reg   <= '0;
            stats_clr_reg <= 1'b1;
            nf_cnt_reg    <= '0;
            nf_max_reg    <= '0;
        end else if (state_reg == DRAIN) begin
            if (frame_done_int) begin
                if (nf_cnt_new != 18'd0) begin
                    pix_cnt_reg   <= nf_cnt_new;
                    max_val_reg   <= nf_max_new;
                    stats_clr_reg <= 1'b0;
                end else begin
                    stats_clr_reg <= 1'b1;
                end
                nf_cnt_reg <= '0;
                nf_max_reg <= '0;
            end else begin
                nf_cnt_reg <= nf_cnt_new;
                nf_max_reg <= nf_max_new;
            end
        end else if (in_valid) begin
            if (stats_clr_reg) begin
                pix_cnt_reg   <= 18'd1;
                max_val_reg   <= sat_in;
                stats_clr_reg <= 1'b0;
            end else begin
                pix_cnt_reg <= pix_cnt_reg + 18'd1;
                max_val_reg <= max_new;
            end
        end
    end

    // Show-ahead head; outputs read as zero while the FIFO is empty
    assign out_valid  = !fifo_empty;
    assign out_data   = out_valid ? mem_data[rd_ptr_reg[AW-1:0]] : '0;
    assign out_col    = out_valid ? mem_col[rd_ptr_reg[AW-1:0]]  : '0;
    assign out_row    = out_valid ? mem_row[rd_ptr_reg[AW-1:0]]  : '0;
    assign out_last   = out_valid ? mem_last[rd_ptr_reg[AW-1:0]] : 1'b0;
    assign overflow   = overflow_reg;
    assign frame_err  = frame_err_reg;
    assign frame_done = frame_done_int;
    assign max_val    = max_val_reg;
    assign pix_cnt    = pix_cnt_reg;

endmodule

// File: doc/conv_result_sink.md
# conv_result_sink

Downstream stage of the 3x3 line-buffer convolution engine. Takes its 19-bit `result`/`o_en`/`done` stream and scales and saturates each sample. Tags each sample with its output-image coordinates and buffers it in a small show-ahead FIFO, which a consumer drains over a valid/ready handshake. Also keeps per-frame statistics (sample count, maximum value) and raises sticky error flags for overflow and malformed frames.

## Interface
- `IN_W`, 19, input sample width (matches the convolution result).
- `OUT_W`, 16, output sample width after saturation.
- `SHIFT`, 0, right shift applied before saturation (0..IN_W-1).
- `OUT_COLS`, 510, output samples per row.
- `OUT_ROWS`, 510, output rows per frame.
- `FIFO_DEPTH`, 8, FIFO entries; must be a power of 2, at least 2.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  sample strobe (convolution `o_en`).
- `in_data`  in  IN_W  sample (convolution `result`).
- `in_done`  in  1  end-of-frame pulse (convolution `done`).
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  consumer accepts the head.
- `out_data`  out  OUT_W  saturated sample.
- `out_col`  out  9  column tag, 0..OUT_COLS-1.
- `out_row`  out  9  row tag, 0..OUT_ROWS-1.
- `out_last`  out  1  head is the final sample of the frame.
- `overflow`  out  1  sticky; a sample was dropped.
- `frame_err`  out  1  sticky; a frame ended with the wrong sample count.
- `frame_done`  out  1  one-cycle pulse when a finished frame is fully drained.
- `max_val`  out  OUT_W  maximum saturated sample of the current or last frame.
- `pix_cnt`  out  18  samples received in the current or last frame.

## Operation
- **Stage 1 (pipeline register)**, loaded on `in_valid`:
  - `s = in_data >> SHIFT`.
  - `sat = (s > 2^OUT_W-1) ? all ones : s[OUT_W-1:0]`.
  - The register also latches the current `col`, `row` and `last`.
- **Coordinate counters**, advanced on every `in_valid`:
  - `col` increments; at `OUT_COLS-1` it wraps to 0 and `row` increments.
  - `last = (col == OUT_COLS-1 && row == OUT_ROWS-1)`.
  - After `last`, both counters return to 0.
- **Stage 2 (FIFO write)** of the stage-1 entry:
  - If the FIFO is full and no pop happens that cycle, the entry is dropped and `overflow` sets.
  - Coordinates still advance on a drop.
  - A write and a pop in the same cycle on a full FIFO both succeed.
- **FIFO output (show-ahead)**:
  - The head drives `out_data`, `out_col`, `out_row`, `out_last`.
  - Pop when `out_valid && out_ready`.
  - `out_valid` is high whenever the FIFO is not empty.
- **Frame statistics**:
  - The first `in_valid` after a `frame_done` (or after reset) clears `pix_cnt` and `max_val` before counting that sample.
  - `pix_cnt` counts every `in_valid`, including dropped samples.
  - `max_val` tracks the maximum `sat` value.
- **End of frame**:
  - `in_done` sets an internal `done_pend` flag.
  - If `in_valid` arrives in the same cycle as `in_done`, that sample belongs to the ending frame.
  - At `in_done`, if the sample count (including any same-cycle sample) ≠ `OUT_COLS*OUT_ROWS`, `frame_err` sets and the coordinate counters force to 0.
  - `frame_done` pulses for one cycle in the first cycle where `done_pend` = 1, stage 1 is empty and the FIFO is empty; `done_pend` then clears.
  - `pix_cnt` and `max_val` hold their values until the next frame's first sample.
- **Clearing**: `overflow` and `frame_err` clear only on `rst`.
- **State machine**:
  - `IDLE`: no frame open.
  - `IDLE` → `RUN` on `in_valid`.
  - `RUN` → `DRAIN` on `in_done`.
  - `DRAIN` → `IDLE` with the `frame_done` pulse.
  - An `in_valid` during `DRAIN` is accepted into the FIFO but belongs to the next frame: it opens a new frame, and statistics clear when `frame_done` fires.

## Timing
- **Reset**: all outputs are 0 during and after `rst`; the FIFO is empty, counters are 0, flags are clear and the state is `IDLE`. Reset mid-frame discards all buffered data.
- **Latency**: `in_valid` in cycle N → `out_valid` in cycle N+2 when the FIFO was empty.
- **Throughput**: one sample per cycle accepted and one popped per cycle. Upstream produces about one sample per 12 cycles.
- **Drain**: the `frame_done` pulse comes no earlier than 1 cycle after the pop of the `out_last` entry.

## Test plan
- **Single sample**: defaults; `in_data=19'h00ABC`, `out_ready=1` → `out_valid` at N+2 for one cycle with `out_data=16'h0ABC`, col 0, row 0, `max_val=16'h0ABC`.
- **Saturation**:
  - `in_data=19'h12345` with `SHIFT=0` → `out_data=16'hFFFF`.
  - Same input with `SHIFT=4` → `out_data=16'h1234`.
- **Full frame** (`OUT_COLS=4`, `OUT_ROWS=3`): 12 samples of value i, then `in_done` →
  - tags run (0,0) through (3,2), with `out_last` only on the 12th;
  - `frame_done` pulses once after the drain;
  - `pix_cnt=12`, `max_val=11`, `frame_err=0`.
- **Backpressure**: `out_ready=0`, 9 back-to-back samples 1..9 →
  - 8 samples are stored and sample 9 is dropped;
  - `overflow=1`, `pix_cnt=9`;
  - after raising `out_ready`, the pops return 1..8 in order.
- **Short frame**: 5 samples then `in_done` → `frame_err=1`; the next frame's first sample is tagged (0,0) and `pix_cnt` restarts at 1.
- **Reset mid-frame**: assert `rst` with 3 entries buffered → all outputs 0 immediately; after release, `out_valid` stays 0 until a new `in_valid`.
